logic_unit_arbiter: RTL and testbench

- Shares one 32-bit bitwise logic unit (AND/OR/NOR/XOR) between two requesters, e.g. the main ALU path and a branch/compare helper.
- Round-robin arbitration with a valid/ready request handshake per requester.
- One registered result slot with a valid/ready response handshake routed back to the granted requester.
- Sits beside the execute stage; the combinational logic unit is its only datapath.

---
 rtl/logic_unit_pkg.sv | 16 +
 rtl/logic_unit32.sv | 34 +++
 rtl/logic_unit_arbiter.sv | 99 +++++++++
 tb/tb_logic_unit_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared encodings for the bitwise logic unit and its two-requester arbiter.
package logic_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOR = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/logic_unit32.sv
// Combinational bitwise logic unit: four parallel gate arrays and a 4:1 select.
module logic_unit32
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] nor_r;
  logic [WIDTH-1:0] xor_r;

  assign and_r = a & b;
  assign or_r  = a | b;
  assign nor_r = ~(a | b);
  assign xor_r = a ^ b;

  always_comb begin
    result = and_r;
    case (op)
      OP_AND:  result = and_r;
      OP_OR:   result = or_r;
      OP_NOR:  result = nor_r;
      OP_XOR:  result = xor_r;
      default: result = and_r;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of one logic unit between two requesters, with a single
// registered result slot returned to whichever requester was granted.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             busy
);

  slot_state_t      state;
  slot_state_t      state_next;
  logic             owner;
  logic             ptr;
  logic             free;
  logic             accept;
  logic             sel;
  logic [1:0]       grant;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] result;

  // Grant and slot next-state; the slot frees in the same cycle its owner drains it
  always_comb begin
    grant      = 2'b00;
    free       = (state == EMPTY) || rsp_ready[owner];
    state_next = state;
    if (free && rst_n) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    accept = |grant;
    sel    = grant[1];
    if (accept) begin
      state_next = FULL;
    end else if ((state == FULL) && rsp_ready[owner]) begin
      state_next = EMPTY;
    end
  end

  assign req_ready = grant;

  assign op_sel = sel ? req_op1 : req_op0;
  assign a_sel  = sel ? req_a1  : req_a0;
  assign b_sel  = sel ? req_b1  : req_b0;

  logic_unit32 #(.WIDTH(WIDTH)) u_lu (
    .op     (op_sel),
    .a      (a_sel),
    .b      (b_sel),
    .result (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Result slot: loads on accept, otherwise holds (including after a drain)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      owner    <= 1'b0;
      ptr      <= 1'b0;
    end else if (accept) begin
      rsp_data <= result;
      rsp_zero <= (result == '0);
      owner    <= sel;
      ptr      <= ~sel;
    end
  end

  assign busy      = (state == FULL);
  assign rsp_valid = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: scoreboard of accepted requests
// plus directed sequences for arbitration, hold, drain and reset behaviour.
module tb_logic_unit_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_op0;
  logic [W-1:0] req_a0;
  logic [W-1:0] req_b0;
  logic [1:0]   req_op1;
  logic [W-1:0] req_a1;
  logic [W-1:0] req_b1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_zero;
  logic         busy;

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_op1   (req_op1),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         owner;
    logic [W-1:0] data;
  } exp_t;

  typedef struct {
    logic         sel;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[8];
  int   total = 0;
  int   bad   = 0;
  logic ptr_m;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compare the head against every visible result, pop on
  // consumption, push on every accepted request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_rsp", W'(rsp_valid), '0);
        end else begin
          check("sb_owner", W'(rsp_valid), W'(sb[0].owner ? 2'b10 : 2'b01));
          check("sb_data", rsp_data, sb[0].data);
          check("sb_zero", W'(rsp_zero), W'(sb[0].data == '0));
          if ((rsp_valid & rsp_ready) != 2'b00) void'(sb.pop_front());
        end
      end
      if (req_valid[0] && req_ready[0]) begin
        mon_e.owner = 1'b0;
        mon_e.data  = model(req_op0, req_a0, req_b0);
        sb.push_back(mon_e);
      end
      if (req_valid[1] && req_ready[1]) begin
        mon_e.owner = 1'b1;
        mon_e.data  = model(req_op1, req_a1, req_b1);
        sb.push_back(mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b0, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    tbl[1] = '{1'b0, 2'b01, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
    tbl[2] = '{1'b0, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F};
    tbl[3] = '{1'b0, 2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    tbl[4] = '{1'b1, 2'b00, 32'h1234_5678, 32'h0F0F_F0F0, 32'h0204_5070};
    tbl[5] = '{1'b1, 2'b01, 32'h1234_5678, 32'h0F0F_F0F0, 32'h1F3F_F6F8};
    tbl[6] = '{1'b1, 2'b10, 32'h1234_5678, 32'h0F0F_F0F0, 32'hE0C0_0907};
    tbl[7] = '{1'b1, 2'b11, 32'h1234_5678, 32'h0F0F_F0F0, 32'h1D3B_A688};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_op0 = 2'b00; req_a0 = '0; req_b0 = '0;
    req_op1 = 2'b00; req_a1 = '0; req_b1 = '0;
    #1;
    check("reset_req_ready", W'(req_ready), '0);
    check("reset_rsp_valid", W'(rsp_valid), '0);
    check("reset_busy", W'(busy), '0);
    check("reset_rsp_data", rsp_data, '0);
    check("reset_rsp_zero", W'(rsp_zero), '0);
    repeat (2) @(posedge clk);
    #2;
    req_valid = 2'b00;
    rst_n     = 1'b1;

    // Single NOR from requester 0
    req_op0 = 2'b10; req_a0 = 32'h0000_FFFF; req_b0 = 32'h00FF_00FF;
    req_valid = 2'b01; rsp_ready = 2'b11;
    @(negedge clk);
    check("t1_req_ready", W'(req_ready), W'(2'b01));
    ptr_m = 1'b1;
    next();
    req_valid = 2'b00;
    @(negedge clk);
    check("t1_rsp_valid", W'(rsp_valid), W'(2'b01));
    check("t1_rsp_data", rsp_data, 32'hFF00_0000);
    check("t1_rsp_zero", W'(rsp_zero), '0);
    next();
    @(negedge clk);
    check("t1_drained", W'(busy), '0);

    // Both requesting every cycle: grants alternate, no idle cycles
    for (int k = 0; k < 8; k++) begin
      next();
      req_valid = 2'b11; rsp_ready = 2'b11;
      req_op0 = 2'($urandom_range(3)); req_a0 = $urandom; req_b0 = $urandom;
      req_op1 = 2'($urandom_range(3)); req_a1 = $urandom; req_b1 = $urandom;
      @(negedge clk);
      check("rr_grant", W'(req_ready), W'(ptr_m ? 2'b10 : 2'b01));
      if (k > 0) check("rr_busy", W'(busy), W'(1'b1));
      ptr_m = ~ptr_m;
    end
    next();
    req_valid = 2'b00;
    @(negedge clk);
    check("rr_last_busy", W'(busy), W'(1'b1));
    next();
    @(negedge clk);
    check("rr_drained", W'(busy), '0);

    // Requester 1 zero result held while its rsp_ready is low
    next();
    req_op1 = 2'b11; req_a1 = 32'hDEAD_BEEF; req_b1 = 32'hDEAD_BEEF;
    req_valid = 2'b10; rsp_ready = 2'b11;
    @(negedge clk);
    check("t3_req_ready", W'(req_ready), W'(2'b10));
    ptr_m = 1'b0;
    next();
    req_op0 = 2'b01; req_a0 = 32'h1; req_b0 = 32'h2;
    req_valid = 2'b01; rsp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_valid", W'(rsp_valid), W'(2'b10));
      check("t3_hold_data", rsp_data, '0);
      check("t3_hold_zero", W'(rsp_zero), W'(1'b1));
      check("t3_hold_no_grant", W'(req_ready), '0);
      next();
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    check("t3_same_cycle_grant", W'(req_ready), W'(2'b01));
    ptr_m = 1'b1;
    next();
    req_valid = 2'b00; rsp_ready = 2'b11;
    @(negedge clk);
    check("t3_reload_valid", W'(rsp_valid), W'(2'b01));
    check("t3_reload_data", rsp_data, 32'h3);
    next();
    @(negedge clk);
    check("t3_drained", W'(busy), '0);

    // Owner 0 ignores rsp_ready on the other bit, then drains
    next();
    req_op0 = 2'b00; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'h1234_5678;
    req_valid = 2'b01; rsp_ready = 2'b10;
    @(negedge clk);
    check("t4_req_ready", W'(req_ready), W'(2'b01));
    ptr_m = 1'b1;
    next();
    req_valid = 2'b00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t4_hold_valid", W'(rsp_valid), W'(2'b01));
      check("t4_hold_data", rsp_data, 32'h1234_5678);
      next();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    check("t4_pre_drain_valid", W'(rsp_valid), W'(2'b01));
    next();
    rsp_ready = 2'b00;
    @(negedge clk);
    check("t4_drain_valid", W'(rsp_valid), '0);
    check("t4_drain_busy", W'(busy), '0);
    check("t4_data_kept", rsp_data, 32'h1234_5678);

    // Asynchronous reset while full, then contested grant goes to requester 0
    next();
    req_op1 = 2'b01; req_a1 = 32'hA; req_b1 = 32'h5;
    req_valid = 2'b10; rsp_ready = 2'b00;
    @(negedge clk);
    check("t5_req_ready", W'(req_ready), W'(2'b10));
    next();
    req_valid = 2'b00;
    @(negedge clk);
    check("t5_full", W'(busy), W'(1'b1));
    #1;
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    check("t5_rst_rsp_valid", W'(rsp_valid), '0);
    check("t5_rst_busy", W'(busy), '0);
    check("t5_rst_rsp_data", rsp_data, '0);
    check("t5_rst_req_ready", W'(req_ready), '0);
    sb.delete();
    ptr_m = 1'b0;
    next();
    req_op0 = 2'b00; req_a0 = 32'h0000_FFFF; req_b0 = 32'h0F0F_0F0F;
    rsp_ready = 2'b11;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_post_reset_grant", W'(req_ready), W'(2'b01));
    next();
    req_valid = 2'b00;
    @(negedge clk);
    check("t5_post_reset_data", rsp_data, 32'h0000_0F0F);
    next();
    @(negedge clk);
    check("t5_drained", W'(busy), '0);

    // Opcode sweep on both requesters
    for (int i = 0; i < 8; i++) begin
      next();
      rsp_ready = 2'b11;
      if (tbl[i].sel) begin
        req_op1 = tbl[i].op; req_a1 = tbl[i].a; req_b1 = tbl[i].b; req_valid = 2'b10;
      end else begin
        req_op0 = tbl[i].op; req_a0 = tbl[i].a; req_b0 = tbl[i].b; req_valid = 2'b01;
      end
      @(negedge clk);
      check("sweep_req_ready", W'(req_ready), W'(tbl[i].sel ? 2'b10 : 2'b01));
      next();
      req_valid = 2'b00;
      @(negedge clk);
      check("sweep_rsp_valid", W'(rsp_valid), W'(tbl[i].sel ? 2'b10 : 2'b01));
      check("sweep_rsp_data", rsp_data, tbl[i].exp);
      check("sweep_rsp_zero", W'(rsp_zero), '0);
    end
    next();
    @(negedge clk);
    check("sb_drained", W'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
